// File: rtl/ofmap_serializer.sv
// ofmap_serializer: deskews systolic-array column outputs into vectors, buffers them, streams words out
module ofmap_serializer #(
  parameter int OFMAP_WIDTH = 32,
  parameter int ARRAY_WIDTH = 4,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [OFMAP_WIDTH*ARRAY_WIDTH-1:0] col_dat,
  input  logic                               col0_vld,
  output logic [OFMAP_WIDTH-1:0]             ofmap_dat,
  output logic                               ofmap_vld,
  input  logic                               ofmap_rdy,
  output logic [$clog2(FIFO_DEPTH):0]        fifo_level,
  output logic                               overflow
);
  localparam int W  = OFMAP_WIDTH;
  localparam int A  = ARRAY_WIDTH;
  localparam int VW = W * A;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int IW = $clog2(A);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state, nxt;
  logic [VW-1:0] aligned, vec;
  logic [VW-1:0] mem [FIFO_DEPTH];
  logic [A-2:0] vsr;
  logic [PW-1:0] wp, rp;
  logic [IW-1:0] idx;
  logic wr_vld, wr_ok, full, empty, xfer, last, pop;
  for (genvar k = 0; k < A; k++) begin : g_col
    if (k == A - 1) begin : g_direct
      assign aligned[k*W +: W] = col_dat[k*W +: W];
    end else begin : g_dly
      logic [W-1:0] d [A-1-k];
      // column k waits A-1-k cycles so every column lines up with the last one
      always_ff @(posedge clk) begin
        d[0] <= col_dat[k*W +: W];
        for (int j = 1; j < A - 1 - k; j++) d[j] <= d[j-1];
      end
      assign aligned[k*W +: W] = d[A-2-k];
    end
  end
  assign wr_vld    = vsr[A-2];
  assign full      = fifo_level == LW'(FIFO_DEPTH);
  assign empty     = fifo_level == '0;
  assign xfer      = state == SEND && ofmap_rdy;
  assign last      = idx == IW'(A - 1);
  assign wr_ok     = wr_vld && (!full || pop);
  assign ofmap_vld = state == SEND;
  assign ofmap_dat = vec[W-1:0];
  // pop on entry from IDLE or on the final word so vectors stream without bubbles
  always_comb begin
    pop = !empty && (state == IDLE || (xfer && last));
    nxt = state == IDLE ? (empty ? IDLE : SEND) : (xfer && last && empty ? IDLE : SEND);
  end
  // control state: valid pipeline, FIFO pointers and level, FSM, shift register
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      vsr        <= '0;
      wp         <= '0;
      rp         <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
      idx        <= '0;
      vec        <= '0;
    end else begin
      state      <= nxt;
      vsr        <= (A-1)'({vsr, col0_vld});
      wp         <= wr_ok ? wp + PW'(1) : wp;
      rp         <= pop ? rp + PW'(1) : rp;
      fifo_level <= fifo_level + LW'(wr_ok) - LW'(pop);
      overflow   <= overflow | (wr_vld && !wr_ok);
      idx        <= pop ? '0 : xfer ? idx + IW'(1) : idx;
      vec        <= pop ? mem[rp] : xfer ? vec >> W : vec;
    end
  end
  // vector storage; a write into a full FIFO lands in the slot being popped this cycle
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wp] <= aligned;
  end
endmodule

// File: tb/tb_ofmap_serializer.sv
// tb_ofmap_serializer: randomized and directed checks against a queue-based reference model
module tb_ofmap_serializer;
  localparam int W  = 32;
  localparam int A  = 4;
  localparam int D  = 4;
  localparam int VW = W * A;
  logic clk = 0, rst = 1, col0_vld = 0, ofmap_rdy = 0, ofmap_vld, overflow;
  logic [VW-1:0] col_dat = '0;
  logic [W-1:0] ofmap_dat;
  logic [$clog2(D):0] fifo_level;
  int total = 0, bad = 0, nw = 0, c = 0;
  logic [VW-1:0] fifo [$];
  logic [W-1:0] cur [$];
  logic [VW-1:0] dh [8];
  logic vh [8];
  logic ovf = 0;
  ofmap_serializer #(.OFMAP_WIDTH(W), .ARRAY_WIDTH(A), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .col_dat(col_dat), .col0_vld(col0_vld),
    .ofmap_dat(ofmap_dat), .ofmap_vld(ofmap_vld), .ofmap_rdy(ofmap_rdy),
    .fifo_level(fifo_level), .overflow(overflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, c);
    end
  endtask
  function automatic logic [VW-1:0] fill(input logic [W-1:0] x);
    return {A{x}};
  endfunction
  function automatic logic [VW-1:0] rnd();
    logic [VW-1:0] r;
    for (int k = 0; k < A; k++) r[k*W +: W] = $urandom;
    return r;
  endfunction
  task automatic model(input logic v, input logic rd, input logic r, input logic [VW-1:0] d);
    logic [VW-1:0] w, h;
    logic wv, pop, was_full;
    int s;
    dh[c % 8] = d;
    if (r) begin
      fifo.delete();
      cur.delete();
      ovf = 0;
      for (int i = 0; i < 8; i++) vh[i] = 0;
      return;
    end
    vh[c % 8] = v;
    s = c - (A - 1);
    wv = s >= 0 && vh[s % 8];
    for (int k = 0; k < A; k++) w[k*W +: W] = dh[(s + k) % 8][k*W +: W];
    if (cur.size() > 0 && rd) void'(cur.pop_front());
    was_full = fifo.size() == D;
    pop = fifo.size() > 0 && cur.size() == 0;
    if (pop) begin
      h = fifo.pop_front();
      for (int k = 0; k < A; k++) cur.push_back(h[k*W +: W]);
    end
    if (wv) begin
      if (was_full && !pop) ovf = 1;
      else fifo.push_back(w);
    end
  endtask
  task automatic step(input logic v, input logic rd, input logic r, input logic [VW-1:0] d);
    col0_vld = v;
    ofmap_rdy = rd;
    rst = r;
    col_dat = d;
    if (ofmap_vld === 1'b1 && rd && !r) nw++;
    @(posedge clk);
    model(v, rd, r, d);
    @(negedge clk);
    chk("vld", ofmap_vld, cur.size() > 0);
    if (cur.size() > 0) chk("dat", ofmap_dat, cur[0]);
    chk("level", fifo_level, fifo.size());
    chk("ovf", overflow, ovf);
    c++;
  endtask
  initial begin
    for (int i = 0; i < 8; i++) vh[i] = 0;
    @(negedge clk);
    step(0, 1, 1, '0);
    step(0, 1, 1, '0);
    chk("rst_dat", ofmap_dat, 0);
    for (int i = 0; i < 10; i++) begin
      step(i == 0, 1, 0, fill(W'(32'h100 + i)));
      if (i < 4) chk("single_pre", ofmap_vld, 0);
      if (i >= 4 && i <= 7) chk("single_word", {ofmap_vld, ofmap_dat}, {1'b1, W'(32'h100 + i - 4)});
      if (i == 8) chk("single_end", ofmap_vld, 0);
    end
    nw = 0;
    for (int i = 0; i < 24; i++) begin
      step(i % 4 == 0 && i < 16, 1, 0, rnd());
      chk("b2b_level", fifo_level <= 1, 1);
    end
    chk("b2b_words", nw, 16);
    for (int i = 0; i < 16; i++) begin
      step(i == 0, !(i >= 5 && i <= 9), 0, fill(W'(32'h100 + i)));
      if (i >= 4 && i <= 9) chk("bp_hold", {ofmap_vld, ofmap_dat}, {1'b1, W'(32'h100)});
      if (i >= 10 && i <= 12) chk("bp_word", ofmap_dat, W'(32'h100 + i - 9));
    end
    for (int i = 0; i < 12; i++) step(i < 6, 0, 0, rnd());
    chk("ovf_level", fifo_level, 4);
    chk("ovf_set", overflow, 1);
    nw = 0;
    for (int i = 0; i < 30; i++) step(0, 1, 0, rnd());
    chk("ovf_words", nw, 20);
    chk("ovf_sticky", overflow, 1);
    step(0, 1, 1, '0);
    chk("ovf_clear", overflow, 0);
    for (int i = 0; i < 10; i++) step(i < 5, 0, 0, rnd());
    nw = 0;
    for (int i = 10; i < 14; i++) step(i == 10, 1, 0, rnd());
    chk("fullpop_level", fifo_level, 4);
    chk("fullpop_ovf", overflow, 0);
    for (int i = 0; i < 30; i++) step(0, 1, 0, rnd());
    chk("fullpop_words", nw, 24);
    for (int i = 0; i < 18; i++) begin
      step(i < 3, 1, i == 7, rnd());
      if (i == 6) chk("mid_level", fifo_level, 2);
      if (i == 7) chk("mid_rst", {ofmap_vld, fifo_level, overflow, ofmap_dat}, '0);
      if (i > 7) chk("mid_quiet", ofmap_vld, 0);
    end
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 4) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 299) == 0, rnd());
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ofmap_serializer.md
# ofmap_serializer

Transmit side of the conv block's ofmap stream. It takes the column-skewed partial-sum outputs of the systolic array and realigns them into one vector per output pixel. Each vector is held in a small vector FIFO and sent one word per handshake on the `ofmap_dat`/`ofmap_vld`/`ofmap_rdy` interface, column 0 first. It is the mirror of the ifmap/weights word-to-vector packers: vector in, words out, with backpressure absorbed by the FIFO.

## Interface
- `OFMAP_WIDTH`, 32: bits per ofmap word.
- `ARRAY_WIDTH`, 4: systolic array columns, which is also the number of words per vector (≥2).
- `FIFO_DEPTH`, 4: aligned vectors buffered (power of two, ≥2).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `col_dat` in `OFMAP_WIDTH*ARRAY_WIDTH`: array `ofmap_out` flattened; column k at bits `[k*OFMAP_WIDTH +: OFMAP_WIDTH]`.
- `col0_vld` in 1: column 0 carries a valid result this cycle. Column k of the same vector is valid exactly k cycles later.
- `ofmap_dat` out `OFMAP_WIDTH`: output word, registered.
- `ofmap_vld` out 1: `ofmap_dat` valid, registered.
- `ofmap_rdy` in 1: downstream accepts.
- `fifo_level` out `$clog2(FIFO_DEPTH)+1`: vectors currently in the FIFO. This count excludes the vector in the shift register.
- `overflow` out 1: sticky; set when an aligned vector is dropped.

## Operation
- **Deskew.** Column k passes through `ARRAY_WIDTH-1-k` pipeline registers. Column `ARRAY_WIDTH-1` is used directly. `col0_vld` is delayed `ARRAY_WIDTH-1` cycles to form `wr_vld`. The aligned vector is valid on the cycle `wr_vld`=1.
- **Deskew throughput.** The deskew stage accepts one new vector per cycle (`col0_vld` may be high every cycle). Values outside a valid window are don't-care and are never written.
- **FIFO write.** When `wr_vld`=1, the aligned vector is written to the FIFO unless the FIFO is full and no pop occurs that cycle.
  - If dropped: the vector is discarded, `overflow` is set, and FIFO contents are unchanged.
  - Full with a simultaneous pop: the write succeeds and the level stays at `FIFO_DEPTH`.
- **Serializer FSM**, state register, two states:
  - IDLE: `ofmap_vld`=0. If the FIFO is non-empty, pop the head into the shift register, set word index=0, go to SEND.
  - SEND: `ofmap_vld`=1 and `ofmap_dat`=word[index]. The word transfers on `ofmap_vld`&&`ofmap_rdy`, and the index increments.
  - On transfer of word `ARRAY_WIDTH-1`: if the FIFO is non-empty, pop the next vector in the same cycle, index=0, stay in SEND (no bubble). Otherwise go to IDLE.
  - With `ofmap_rdy`=0, `ofmap_dat` and `ofmap_vld` hold stable.
- **Data handling.** Data passes bit-exact; there is no sign handling or arithmetic.
- **`fifo_level`.** Adds +1 on a successful write, −1 on a pop, and is unchanged when both occur.
- **Pointers.** Read and write pointers wrap modulo `FIFO_DEPTH`. Full/empty is decided by the level counter.
- **Reset.** All state is cleared synchronously: FSM→IDLE, `ofmap_vld`=0, `ofmap_dat`=0, `fifo_level`=0, `overflow`=0, deskew valid pipeline cleared, FIFO pointers=0.
  - Reset asserted mid-vector or mid-deskew aborts everything; partially sent vectors are lost.
  - Datapath delay registers need not be reset.

## Timing
- Call the cycle with `col0_vld`=1 cycle t.
  - Column k is sampled at t+k.
  - The vector is written at the edge ending t+`ARRAY_WIDTH`-1.
  - The FIFO is non-empty in t+`ARRAY_WIDTH`; the pop occurs at the end of that cycle.
  - The first `ofmap_vld` is at t+`ARRAY_WIDTH`+1, which is cycle 5 for the defaults.
- With `ofmap_rdy` held at 1, a vector occupies exactly `ARRAY_WIDTH` consecutive output cycles.
- Back-to-back vectors produce a continuous stream.
- Sustained input rate above 1 vector per `ARRAY_WIDTH` cycles eventually overflows. This is by design: the array cannot stall, and upstream scheduling guarantees the rate.
- `overflow` rises the cycle after the dropped write and stays high until `rst`.
- With `rst`=1, outputs read reset values in the following cycle.

## Test plan
- **Single vector.** Pulse `col0_vld` at cycle 0 with column k = 0x100+k, each at cycle k; `ofmap_rdy`=1. Expect `ofmap_vld` in cycles 5–8 carrying 0x100, 0x101, 0x102, 0x103, then 0.
- **Back-to-back.** Send 4 vectors with `col0_vld` every 4 cycles; `ofmap_rdy`=1. Expect 16 contiguous valid words in order, `fifo_level` ≤1, `overflow`=0.
- **Backpressure.** Same as the single-vector case, but `ofmap_rdy`=0 during cycles 5–9, then 1. Expect `ofmap_dat`=0x100 held stable through the stall, then all 4 words in order, none duplicated.
- **Overflow.** `ofmap_rdy`=0 and 6 vectors with `col0_vld` every cycle. Expect:
  - `fifo_level`=4.
  - `overflow`=1 after vector 6 is dropped (one vector sits in the shift register).
  - After `ofmap_rdy`=1, exactly 5 vectors (20 words) emerge, in order.
- **Full with simultaneous pop.** FIFO full, last word of the current vector transfers in the same cycle as a new write. Expect `fifo_level` stays 4, `overflow` stays 0, no data lost.
- **Reset mid-stream.** Assert `rst` for 1 cycle during word 2 of a vector with 2 vectors queued. Expect the next cycle `ofmap_vld`=0, `fifo_level`=0, `overflow`=0, and no further output words until new input.
